// File: rtl/writeback_unit.sv
// Writeback arbiter: merges an unstalled ALU result stream with a queued
// load-result stream into one registered register-file write port, and
// keeps a per-register scoreboard of loads still in flight.
module writeback_unit #(
    parameter int LQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [4:0]                alu_rd,
    input  logic [31:0]               alu_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [4:0]                ld_rd,
    input  logic [31:0]               ld_data,
    input  logic                      issue_ld,
    input  logic [4:0]                issue_rd,
    output logic                      rf_we,
    output logic [5:0]                rf_rd,
    output logic [31:0]               rf_data,
    output logic [31:0]               pending,
    output logic [$clog2(LQ_DEPTH):0] lq_count
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(LQ_DEPTH);

    logic [4:0]    lq_rd   [LQ_DEPTH];
    logic [31:0]   lq_data [LQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          push;
    logic          pop;
    logic          sel_valid;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;
    logic [31:0]   pending_nxt;

    // Queue handshake, ALU-first arbitration and scoreboard next value.
    // pop only looks at the registered count, so an entry pushed this cycle
    // can never be popped in the same cycle.
    always_comb begin
        ld_ready  = (lq_count < DEPTH_C);
        push      = ld_valid && ld_ready;
        pop       = !alu_valid && (lq_count != '0);
        sel_valid = alu_valid || pop;
        sel_rd    = alu_valid ? alu_rd   : lq_rd[rd_ptr];
        sel_data  = alu_valid ? alu_data : lq_data[rd_ptr];

        set_mask = '0;
        clr_mask = '0;
        if (issue_ld && (issue_rd != 5'd0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (pop) begin
            clr_mask[lq_rd[rd_ptr]] = 1'b1;
        end
        // Set is applied after clear so a same-cycle reissue keeps the bit.
        pending_nxt    = (pending & ~clr_mask) | set_mask;
        pending_nxt[0] = 1'b0;
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd[wr_ptr]   <= ld_rd;
            lq_data[wr_ptr] <= ld_data;
        end
    end

    // Pointers, occupancy, scoreboard and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lq_count <= '0;
            pending  <= '0;
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   lq_count <= lq_count + 1'b1;
                2'b01:   lq_count <= lq_count - 1'b1;
                default: lq_count <= lq_count;
            endcase
            pending <= pending_nxt;
            // x0 writes are still consumed, they just never assert rf_we.
            rf_we <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                rf_rd   <= {1'b0, sel_rd};
                rf_data <= sel_data;
            end
        end
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter LQ_DEPTH, default 4, meaning load-result queue entries; power of two, >= 2.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port alu_valid, input, 1, meaning an ALU result is presented this cycle; no backpressure.
REQ-005 SHALL have port alu_rd, input, 5, the ALU destination register.
REQ-006 SHALL have port alu_data, input, 32, the ALU result.
REQ-007 SHALL have port ld_valid, input, 1, meaning a load result is offered.
REQ-008 SHALL have port ld_ready, output, 1, meaning the queue accepts a load result this cycle.
REQ-009 SHALL have port ld_rd, input, 5, the load destination register.
REQ-010 SHALL have port ld_data, input, 32, the load result.
REQ-011 SHALL have port issue_ld, input, 1, meaning a load to issue_rd was issued this cycle.
REQ-012 SHALL have port issue_rd, input, 5, the issued load's destination register.
REQ-013 SHALL have port rf_we, output, 1, the register-file write enable.
REQ-014 SHALL have port rf_rd, output, 6, the register-file write index; bit 5 is always 0.
REQ-015 SHALL have port rf_data, output, 32, the register-file write data.
REQ-016 SHALL have port pending, output, 32, one bit per register with an outstanding load; bit 0 is always 0.
REQ-017 SHALL have port lq_count, output, $clog2(LQ_DEPTH)+1, the current queue occupancy.

Function
REQ-018 rf_we, rf_rd and rf_data SHALL be registered; an event selected in cycle N appears on them in cycle N+1 only.
REQ-019 Load push SHALL occur when ld_valid && ld_ready; ld_ready SHALL equal (lq_count < LQ_DEPTH) and SHALL ignore a same-cycle pop.
REQ-020 Queue SHALL be FIFO-ordered; read and write pointers SHALL wrap modulo LQ_DEPTH.
REQ-021 Arbitration: when alu_valid=1, the ALU result SHALL be selected; otherwise the queue head, if non-empty, SHALL be popped and selected.
REQ-022 A pushed entry SHALL NOT be popped in its push cycle; the earliest write is at push cycle + 2.
REQ-023 Simultaneous push and pop SHALL leave lq_count unchanged and preserve order.
REQ-024 A selected event with rd=0 SHALL drive rf_we=0 the next cycle; a queue entry with rd=0 SHALL still be popped.
REQ-025 With no event selected, rf_we SHALL be 0 the next cycle, and rf_rd/rf_data SHALL hold their previous values.
REQ-026 pending[issue_rd] SHALL be set on the clock edge after issue_ld=1, for issue_rd != 0.
REQ-027 pending[rd] SHALL clear on the edge at which a queue entry for rd is popped.
REQ-028 When a set and a clear hit the same register in one cycle, the set SHALL win.
REQ-029 alu_valid with pending[alu_rd]=1 is an upstream protocol violation; the bench SHALL flag it with an assertion, and the RTL need not handle it.
REQ-030 lq_count SHALL never exceed LQ_DEPTH; the queue SHALL never underflow.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock, force rf_we=0, rf_rd=0, rf_data=0, pending=0, lq_count=0, both pointers to 0, and ld_ready=1.
REQ-032 Reset mid-operation SHALL discard all queued loads and pending bits; no rf_we pulse SHALL follow reset release until a new event is selected.
REQ-033 Queue storage data need not be reset.

Verification
REQ-034 ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF in cycle N -> rf_we=1, rf_rd=5, rf_data=0xDEADBEEF in N+1; rf_we=0 in N+2.
REQ-035 Priority: push load (rd=3, 0x11) in N; alu_valid (rd=7, 0x22) in N+1 -> ALU write (rd=7) in N+2, then load write (rd=3) in N+3.
REQ-036 Full queue with LQ_DEPTH=4: push 4 loads under continuous alu_valid -> lq_count=4, ld_ready=0; a fifth ld_valid is not accepted; drop alu_valid -> writes occur in push order on 4 consecutive cycles.
REQ-037 Scoreboard: issue_ld with rd=9 -> pending[9]=1 next cycle; pop of a rd=9 entry coinciding with a new issue_ld to rd=9 -> pending[9] stays 1.
REQ-038 x0: alu_rd=0 or a popped load with rd=0 -> rf_we stays 0, and lq_count decrements for the load.
REQ-039 Async reset: assert rst_n=0 between clock edges with 2 loads queued -> outputs and lq_count are 0 before the next edge; no writes after release.
